mfp_ahb_timer: RTL and testbench

//  AHB-Lite slave interval timer on the mfp_ahb bus, decoded beside GPIO/7-seg; consumes core HADDR/HWDATA/HWRITE.

---
 rtl/mfp_ahb_timer_pkg.sv | 24 ++
 rtl/mfp_timer_prescaler.sv | 31 +++
 rtl/mfp_ahb_timer.sv | 152 +++++++++++++++
 tb/tb_mfp_ahb_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_timer_pkg.sv
// Shared definitions for the mfp_ahb interval timer: register word indices
// and CTRL/STATUS bit positions.
package mfp_ahb_timer_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_LOAD   = 3'd1,
    REG_COUNT  = 3'd2,
    REG_STATUS = 3'd3,
    REG_PRESC  = 3'd4,
    REG_CMP    = 3'd5
  } tmr_reg_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  // Byte offset of a register as seen on HADDR.
  function automatic logic [4:0] reg_offset(tmr_reg_e r);
    return {r, 2'b00};
  endfunction

endpackage

// File: rtl/mfp_timer_prescaler.sv
// Prescaler for the interval timer: emits one tick every (presc+1) enabled
// clocks; restart zeroes the phase so a new period starts cleanly.
module mfp_timer_prescaler
  import mfp_ahb_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               restart,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;

  assign tick = en && (pcnt_q == presc);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (restart) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= tick ? '0 : pcnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/mfp_ahb_timer.sv
// AHB-Lite interval timer: prescaled 32-bit down-counter with auto-reload and
// level IRQ. Define MFP_TIMER_PWM_EN to add the CMP register and TMR_PWM output.
module mfp_ahb_timer
  import mfp_ahb_timer_pkg::*;
#(
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              TMR_IRQ,
  output logic              TMR_PWM
);

  logic [ADDR_W-3:0]  waddr_q;
  logic               wr_pend_q, rd_pend_q;
  logic               en_q, ar_q, ie_q, exp_q, irq_q;
  logic [31:0]        load_q, count_q;
  logic [PRESC_W-1:0] presc_q;

  logic [2:0] word_idx;
  logic       reg_hit;
  logic       wr_ctrl, wr_load, wr_status, wr_presc;
  logic       tick, tick_eff, expire, restart;
  logic       unused_bits;

  assign unused_bits = ^{HADDR[1:0], HTRANS[0]};

  assign word_idx  = waddr_q[2:0];
  assign reg_hit   = (waddr_q >> 3) == '0;
  assign wr_ctrl   = wr_pend_q && reg_hit && (word_idx == REG_CTRL);
  assign wr_load   = wr_pend_q && reg_hit && (word_idx == REG_LOAD);
  assign wr_status = wr_pend_q && reg_hit && (word_idx == REG_STATUS);
  assign wr_presc  = wr_pend_q && reg_hit && (word_idx == REG_PRESC);

  // A LOAD write swallows a coincident tick: no decrement and no expiry.
  assign tick_eff = tick && !wr_load;
  assign expire   = tick_eff && (count_q == '0);
  assign restart  = wr_load || (wr_ctrl && HWDATA[CTRL_EN] && !en_q);

  mfp_timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .en      (en_q),
    .restart (restart),
    .presc   (presc_q),
    .tick    (tick)
  );

  // Address phase capture; the slave is zero-wait so the data phase is one cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      waddr_q   <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else if (HREADY) begin
      wr_pend_q <= HSEL && HTRANS[1] && HWRITE;
      rd_pend_q <= HSEL && HTRANS[1] && !HWRITE;
      if (HSEL && HTRANS[1]) waddr_q <= HADDR[ADDR_W-1:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
    end else begin
      if (tick_eff) begin
        if (expire) begin
          exp_q <= 1'b1;
          if (ar_q) count_q <= load_q;
          else      en_q    <= 1'b0;
        end else begin
          count_q <= count_q - 32'd1;
        end
      end
      // Bus writes follow the counter updates so a later assignment overrides the hardware one.
      if (wr_ctrl) begin
        en_q <= HWDATA[CTRL_EN];
        ar_q <= HWDATA[CTRL_AR];
        ie_q <= HWDATA[CTRL_IE];
      end
      if (wr_load) begin
        load_q  <= HWDATA;
        count_q <= HWDATA;
      end
      if (wr_status && HWDATA[STATUS_EXP] && !expire) exp_q <= 1'b0;
      if (wr_presc) presc_q <= HWDATA[PRESC_W-1:0];
      irq_q <= exp_q && ie_q;
    end
  end

  assign TMR_IRQ = irq_q;

`ifdef MFP_TIMER_PWM_EN
  logic [31:0] cmp_q;
  logic        pwm_q;
  logic        wr_cmp;

  assign wr_cmp = wr_pend_q && reg_hit && (word_idx == REG_CMP);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cmp_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      if (wr_cmp) cmp_q <= HWDATA;
      pwm_q <= en_q && (count_q < cmp_q);
    end
  end

  assign TMR_PWM = pwm_q;
`else
  assign TMR_PWM = 1'b0;
`endif

  always_comb begin
    // NOTE: defaulting every output first keeps this block purely combinational (no latches).
    HRDATA = '0;
    if (rd_pend_q && reg_hit) begin
      case (word_idx)
        REG_CTRL: begin
          HRDATA[CTRL_EN] = en_q;
          HRDATA[CTRL_AR] = ar_q;
          HRDATA[CTRL_IE] = ie_q;
        end
        REG_LOAD:   HRDATA = load_q;
        REG_COUNT:  HRDATA = count_q;
        REG_STATUS: HRDATA[STATUS_EXP] = exp_q;
        REG_PRESC:  HRDATA[PRESC_W-1:0] = presc_q;
`ifdef MFP_TIMER_PWM_EN
        REG_CMP:    HRDATA = cmp_q;
`endif
        default:    HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_timer.sv
// Directed self-checking bench for mfp_ahb_timer (default and MFP_TIMER_PWM_EN builds).
module tb_mfp_ahb_timer;
  import mfp_ahb_timer_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [4:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        TMR_IRQ;
  logic        TMR_PWM;

  int n_checks = 0;
  int n_pass   = 0;

  mfp_ahb_timer #(.PRESC_W(16), .ADDR_W(5)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HREADY  (HREADY),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .TMR_IRQ (TMR_IRQ),
    .TMR_PWM (TMR_PWM)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [4:0] a, input logic wr);
    HSEL   = 1'b1;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = wr;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    step();
    bus_idle();
    HWDATA = d;
    step();
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    step();
    bus_idle();
    d = HRDATA;
    step();
  endtask

  logic [4:0] A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESC, A_CMP;
  logic [31:0] rd;
  int exp_cnt [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int exp_irq [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int cycles;
  int hi;
  int pwm_exp;
  int cmp_exp;

  initial begin
    A_CTRL   = reg_offset(REG_CTRL);
    A_LOAD   = reg_offset(REG_LOAD);
    A_COUNT  = reg_offset(REG_COUNT);
    A_STATUS = reg_offset(REG_STATUS);
    A_PRESC  = reg_offset(REG_PRESC);
    A_CMP    = reg_offset(REG_CMP);
`ifdef MFP_TIMER_PWM_EN
    pwm_exp = 10;
    cmp_exp = 5;
`else
    pwm_exp = 0;
    cmp_exp = 0;
`endif

    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HADDR   = '0;
    HWDATA  = '0;
    bus_idle();
    repeat (3) step();
    check("rst_irq", {31'd0, TMR_IRQ}, 32'd0);
    check("rst_pwm", {31'd0, TMR_PWM}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    HRESETn = 1'b1;
    step();
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    bus_read(A_LOAD, rd);   check("rst_load", rd, 32'd0);
    bus_read(A_COUNT, rd);  check("rst_count", rd, 32'd0);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'd0);
    bus_read(A_PRESC, rd);  check("rst_presc", rd, 32'd0);
    bus_read(A_CMP, rd);    check("rst_cmp", rd, 32'd0);

    // Auto-reload, tick every cycle: COUNT 3..0 with EXP/IRQ on the 4th tick.
    bus_write(A_PRESC, 32'd0);
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'h7);
    addr_phase(A_COUNT, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("ar_count[%0d]", i), HRDATA, exp_cnt[i]);
      check($sformatf("ar_irq[%0d]", i), {31'd0, TMR_IRQ}, exp_irq[i]);
    end
    bus_idle();
    step();
    step();
    // This W1C commits on the same edge as the next expiry.
    bus_write(A_STATUS, 32'h1);
    check("w1c_race_irq", {31'd0, TMR_IRQ}, 32'd1);
    bus_read(A_STATUS, rd); check("w1c_race_exp", rd, 32'd1);
    bus_write(A_CTRL, 32'h4);
    check("stop_irq", {31'd0, TMR_IRQ}, 32'd1);
    bus_write(A_STATUS, 32'h1);
    check("w1c_irq_lag", {31'd0, TMR_IRQ}, 32'd1);
    step();
    check("w1c_irq_drop", {31'd0, TMR_IRQ}, 32'd0);
    bus_read(A_STATUS, rd); check("w1c_exp_clr", rd, 32'd0);
    bus_read(A_COUNT, rd);  check("frozen_count", rd, 32'd3);

    // One-shot: PRESC=9, LOAD=1 expires 20 clocks after enable.
    bus_write(A_PRESC, 32'd9);
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'h1);
    addr_phase(A_STATUS, 1'b0);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!HRDATA[0] && cycles < 40);
    bus_idle();
    check("oneshot_cycles", cycles, 32'd20);
    bus_read(A_CTRL, rd);  check("oneshot_ctrl", rd, 32'd0);
    bus_read(A_COUNT, rd); check("oneshot_count", rd, 32'd0);
    repeat (5) step();
    bus_read(A_COUNT, rd);  check("oneshot_hold", rd, 32'd0);
    bus_read(A_STATUS, rd); check("oneshot_exp", rd, 32'd1);
    check("oneshot_noirq", {31'd0, TMR_IRQ}, 32'd0);

    // Back-to-back: LOAD write data phase overlaps the COUNT read address phase.
    addr_phase(A_LOAD, 1'b1);
    step();
    HWDATA = 32'h10;
    addr_phase(A_COUNT, 1'b0);
    step();
    check("b2b_count", HRDATA, 32'h10);
    bus_idle();
    step();
    bus_read(A_LOAD, rd);  check("load_rd", rd, 32'h10);
    bus_read(A_PRESC, rd); check("presc_rd", rd, 32'd9);
    bus_read(5'h18, rd);   check("unmapped_rd", rd, 32'd0);
    bus_write(5'h18, 32'hFFFF_FFFF);
    check("idle_hrdata", HRDATA, 32'd0);
    HSEL   = 1'b1;
    HADDR  = A_LOAD;
    HTRANS = 2'b00;
    HWRITE = 1'b1;
    step();
    bus_idle();
    HWDATA = 32'hDEAD;
    step();
    bus_read(A_LOAD, rd);  check("idle_write_load", rd, 32'h10);
    bus_read(A_COUNT, rd); check("idle_write_count", rd, 32'h10);
    bus_write(A_CMP, 32'd5);
    bus_read(A_CMP, rd);   check("cmp_rd", rd, cmp_exp);

    // LOAD write landing on a tick edge wins over the decrement.
    bus_write(A_PRESC, 32'd0);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_LOAD, 32'd5);
    bus_read(A_COUNT, rd); check("load_vs_tick", rd, 32'd4);

    // PWM: LOAD=9, CMP=5 gives 5 high cycles per 10.
    bus_write(A_LOAD, 32'd9);
    repeat (12) step();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi += int'(TMR_PWM);
    end
    check("pwm_high", hi, pwm_exp);

    // Reset asserted during a write data phase discards the write.
    addr_phase(A_LOAD, 1'b1);
    step();
    bus_idle();
    HWDATA  = 32'h55;
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    step();
    bus_read(A_LOAD, rd);   check("midrst_load", rd, 32'd0);
    bus_read(A_CTRL, rd);   check("midrst_ctrl", rd, 32'd0);
    bus_read(A_STATUS, rd); check("midrst_status", rd, 32'd0);
    check("midrst_irq", {31'd0, TMR_IRQ}, 32'd0);
    check("midrst_pwm", {31'd0, TMR_PWM}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
